// File: rtl/lcd_cgram_loader_pkg.sv
// Shared constants for the LCD power-on loader: HD44780 commands, glyph codes,
// the custom glyph bitmaps and the sequencer state type.
package lcd_pkg;

   localparam logic [7:0] LCD_FUNC_SET   = 8'h38;
   localparam logic [7:0] LCD_DISP_ON    = 8'h0C;
   localparam logic [7:0] LCD_ENTRY_INC  = 8'h06;
   localparam logic [7:0] LCD_CLEAR      = 8'h01;
   localparam logic [7:0] LCD_CGRAM_BASE = 8'h40;
   localparam logic [7:0] LCD_DDRAM_BASE = 8'h80;

   localparam logic [7:0] GLYPH_BUNNY0 = 8'd0;
   localparam logic [7:0] GLYPH_BUNNY1 = 8'd1;
   localparam logic [7:0] GLYPH_BUNNY2 = 8'd2;
   localparam logic [7:0] GLYPH_OBST0  = 8'd3;
   localparam logic [7:0] GLYPH_OBST1  = 8'd4;
   localparam logic [7:0] GLYPH_OBST2  = 8'd5;

   localparam int unsigned GLYPH_BYTES = 48;

   localparam logic [5:0] STEP_CLEAR       = 6'd3;
   localparam logic [5:0] STEP_CGRAM       = 6'd4;
   localparam logic [5:0] STEP_GLYPH_FIRST = 6'd5;
   localparam logic [5:0] STEP_GLYPH_LAST  = 6'd52;
   localparam logic [5:0] STEP_LAST        = 6'd53;

   // Row r of glyph g lives at index g*8+r, matching CGRAM auto-increment order.
   localparam logic [7:0] GLYPH_ROM [0:47] = '{
      8'h0A, 8'h0A, 8'h0A, 8'h0E, 8'h1F, 8'h15, 8'h1F, 8'h0E,
      8'h0E, 8'h1F, 8'h1F, 8'h1F, 8'h1F, 8'h0E, 8'h00, 8'h00,
      8'h00, 8'h0E, 8'h1F, 8'h1F, 8'h1B, 8'h11, 8'h11, 8'h1B,
      8'h04, 8'h04, 8'h15, 8'h15, 8'h1F, 8'h04, 8'h04, 8'h04,
      8'h00, 8'h00, 8'h00, 8'h0E, 8'h1F, 8'h1F, 8'h1F, 8'h1F,
      8'h00, 8'h10, 8'h18, 8'h1F, 8'h06, 8'h04, 8'h00, 8'h00
   };

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_DONE
   } lcd_state_e;

endpackage

// File: rtl/lcd_cgram_loader_if.sv
// LCD bus plus loader status/control, shared between the loader and its consumer.
interface lcd_cgram_loader_if;
   logic [7:0] lcd_data;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_en;
   logic       busy;
   logic       done;
   logic       reload;

   modport master (
      output lcd_data, lcd_rs, lcd_rw, lcd_en, busy, done,
      input  reload
   );

   modport slave (
      input  lcd_data, lcd_rs, lcd_rw, lcd_en, busy, done,
      output reload
   );
endinterface

// File: rtl/lcd_cgram_loader_glyph_rom.sv
// Combinational glyph bitmap lookup; indices past the table read as zero.
module lcd_glyph_rom
   import lcd_pkg::*;
(
   input  logic [5:0] idx,
   output logic [7:0] row
);
   always_comb begin
      row = '0;
      if (idx < 6'(GLYPH_BYTES)) row = GLYPH_ROM[idx];
   end
endmodule

// File: rtl/lcd_cgram_loader.sv
// Power-on sequencer: HD44780 init, CGRAM glyph load, then holds done until a reload.
module lcd_cgram_loader
   import lcd_pkg::*;
#(
   parameter int unsigned EN_HIGH      = 2,
   parameter int unsigned WAIT_CYC     = 4,
   parameter int unsigned CLR_WAIT_CYC = 16
) (
   input logic                clk,
   input logic                rst,
   lcd_cgram_loader_if.master bus
);
   localparam int unsigned CNT_MAX = (CLR_WAIT_CYC > EN_HIGH) ? CLR_WAIT_CYC : EN_HIGH;
   localparam int unsigned CNT_W   = ($clog2(CNT_MAX + 1) > 5) ? $clog2(CNT_MAX + 1) : 5;

   localparam logic [CNT_W-1:0] EN_LOAD   = CNT_W'(EN_HIGH - 1);
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] CLR_LOAD  = CNT_W'(CLR_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   lcd_state_e       state_q, state_d;
   logic [5:0]       step_q, step_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       data_q, data_d;
   logic             rs_q, rs_d;
   logic             en_q, en_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [5:0]       rom_idx;
   logic [7:0]       rom_row;

   assign rom_idx = step_d - STEP_GLYPH_FIRST;

   lcd_glyph_rom u_rom (
      .idx (rom_idx),
      .row (rom_row)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         step_q  <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         rs_q    <= 1'b0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         rs_q    <= rs_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin : next_state
      state_d = state_q;
      step_d  = step_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE:  state_d = ST_SETUP;
         ST_SETUP: begin
            state_d = ST_PULSE;
            cnt_d   = EN_LOAD;
         end
         ST_PULSE: begin
            if (cnt_q == '0) begin
               state_d = ST_HOLD;
               cnt_d   = (step_q == STEP_CLEAR) ? CLR_LOAD : WAIT_LOAD;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               if (step_q == STEP_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_SETUP;
                  step_d  = step_q + 6'd1;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_DONE: begin
            if (bus.reload) begin
               state_d = ST_SETUP;
               step_d  = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every bus pin comes straight off a flop.
   always_comb begin : out_decode
      data_d = '0;
      rs_d   = 1'b0;
      en_d   = (state_d == ST_PULSE);
      busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_d = (state_d == ST_DONE);
      if (busy_d) begin
         rs_d = (step_d >= STEP_GLYPH_FIRST) && (step_d <= STEP_GLYPH_LAST);
         case (step_d)
            6'd0:       data_d = LCD_FUNC_SET;
            6'd1:       data_d = LCD_DISP_ON;
            6'd2:       data_d = LCD_ENTRY_INC;
            STEP_CLEAR: data_d = LCD_CLEAR;
            STEP_CGRAM: data_d = LCD_CGRAM_BASE;
            STEP_LAST:  data_d = LCD_DDRAM_BASE;
            default:    data_d = rom_row;
         endcase
      end
   end

   assign bus.lcd_data = data_q;
   assign bus.lcd_rs   = rs_q;
   assign bus.lcd_rw   = 1'b0;
   assign bus.lcd_en   = en_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

endmodule
